sram_write_monitor: RTL and testbench
=====================================

# sram_write_monitor

Synthesizable, parametrised monitor that observes the SRAM write port inside `project`, between the milestone write masters and the SRAM controller. It classifies every write into one of `NUM_REGIONS` programmable address windows and keeps per-region statistics: write count, order errors, completion and a data signature. It also raises a sticky violation on any write into a forbidden region. Its purpose is on-board self-checking of decoded output, and it gives the bench a compact signature to compare against golden values.

## Interface
- `ADDR_W`, 18: SRAM word address width.
- `DATA_W`, 16: SRAM data width.
- `NUM_REGIONS`, 4: number of address windows (≥1).
- `CNT_W`, 20: width of all counters (saturating).
- `SIG_W`, 32: signature width.

Ports:
- `Clock_50`  in  1: sole clock; all state changes on its rising edge.
- `Resetn`  in  1: asynchronous, active-low reset.
- `Start`  in  1: one-cycle pulse. Clears all statistics and enters ARMED.
- `Stop`  in  1: one-cycle pulse. ARMED→FROZEN.
- `SRAM_we_n`  in  1: active-low write strobe, as driven to the SRAM controller.
- `SRAM_address`  in  ADDR_W: write address.
- `SRAM_write_data`  in  DATA_W: write data.
- `Region_base`  in  NUM_REGIONS*ADDR_W: packed inclusive lower bounds; region r at `[r*ADDR_W +: ADDR_W]`.
- `Region_limit`  in  NUM_REGIONS*ADDR_W: packed inclusive upper bounds.
- `Region_forbid`  in  NUM_REGIONS: 1 = any write into the region is a violation.
- `Region_ordered`  in  NUM_REGIONS: 1 = region is checked for strictly sequential writes.
- `Read_sel`  in  max(1,$clog2(NUM_REGIONS)): region selected for readout.
- `Read_count`, `Read_order_err`  out  CNT_W: write count and order-error count of the selected region.
- `Read_sig`  out  SIG_W: signature of the selected region.
- `Read_complete`  out  1: selected region complete.
- `Unmapped_count`  out  CNT_W: writes hitting no region.
- `Violation`  out  1: sticky forbidden-write flag.
- `Violation_address`  out  ADDR_W, `Violation_data`  out  DATA_W: capture of the first violating write.
- `Armed`  out  1: high in ARMED.

## Operation
- FSM states: IDLE (reset), ARMED, FROZEN.
  - IDLE/FROZEN --Start--> ARMED, with all statistics cleared.
  - ARMED --Stop--> FROZEN.
  - ARMED --Start--> ARMED, with statistics cleared (restart).
  - If `Start` and `Stop` are high in the same cycle, `Start` wins.
- A write is sampled when the state is ARMED and `SRAM_we_n`==0 at the rising edge.
  - Writes in IDLE or FROZEN are ignored.
  - A write in the cycle `Start` is high is ignored.
  - A write in the cycle `Stop` is high is counted.
- Region match: base ≤ address ≤ limit. The lowest matching index wins. A region with base > limit never matches. No match increments `Unmapped_count`.
- Matched region r:
  - count_r += 1, saturating at 2^CNT_W−1.
  - sig_r ← rotl1(sig_r) XOR low SIG_W bits of {address, data}, zero-extended if narrower.
  - If `Region_forbid[r]`: set `Violation`. On the first violation only, capture address and data. Later violations do not overwrite the capture.
  - If `Region_ordered[r]`: expected_r is set to base_r on Start. If address ≠ expected_r, order_err_r += 1 (saturating). In both cases expected_r ← address+1, which resyncs after a skip or repeat.
  - complete_r sets when an ordered region accepts a write with address == limit_r while order_err_r == 0 (counting this write's check). Once set, it stays set until Start. Unordered regions never report complete.
- Region bounds and mode inputs must be stable while ARMED. Changing them mid-run is legal but applies from the next sampled write.

## Timing
- Reset values:
  - state IDLE, `Armed`=0.
  - All counters, signatures, `Violation`, `Violation_address`, `Violation_data` = 0.
  - complete = 0; expected = 0.
  - `Unmapped_count` = 0.
- Statistics update on the sampling edge and are visible on outputs one cycle later.
- `Read_*` outputs are registered: the value reflects `Read_sel` and the statistics as of the previous edge (1-cycle latency).
- `Armed` rises the cycle after a Start edge and falls the cycle after a Stop edge.
- Back-to-back writes on every cycle are supported with no stalls.
- Reset asserted mid-run clears everything immediately and asynchronously. No Start is needed to reach IDLE.

## Test plan
- Reset, then Start. Write addresses 0x100..0x10F (data = address) into region 0 (base 0x100, limit 0x10F, ordered). Then Stop and read region 0 → count=16, order_err=0, complete=1, and sig equals the reference model value.
- Same region, address sequence 0x100,0x101,0x101,0x103..0x10F → order_err=2 (one repeat, one skip), complete=0, count=16.
- Region 1 forbidden at 0x0000..0x23DFF. Write 0x00010/0xBEEF, then 0x00020/0x1234 → `Violation`=1, capture = 0x00010/0xBEEF.
- Overlapping regions 0 (0x0..0xFF) and 1 (0x80..0x1FF). Write 0x90 → only region 0 count=1. Write 0x300 → `Unmapped_count`=1.
- Writes while IDLE, while FROZEN and in the Start cycle → no counter change. A write in the Stop cycle → counted (count=1).
- Assert `Resetn` low mid-run after 5 writes → all outputs 0 within the same cycle. `Start` with `Stop` in the same cycle → `Armed`=1 next cycle.

Source files
------------

// File: rtl/sram_write_monitor.sv
`default_nettype none
// ============================================================================
// Module   : sram_write_monitor
// Brief    : Observes the SRAM write port. Classifies each write into one of
//            NUM_REGIONS programmable address windows and keeps per-region
//            write count, order-error count, completion flag and signature.
//            Flags writes into forbidden windows with a sticky violation.
// Revision : 1.0 - initial release
// ============================================================================
module sram_write_monitor #(
    parameter int ADDR_W      = 18,
    parameter int DATA_W      = 16,
    parameter int NUM_REGIONS = 4,
    parameter int CNT_W       = 20,
    parameter int SIG_W       = 32
) (
    input  logic                                           Clock_50,
    input  logic                                           Resetn,
    input  logic                                           Start,
    input  logic                                           Stop,
    input  logic                                           SRAM_we_n,
    input  logic [ADDR_W-1:0]                              SRAM_address,
    input  logic [DATA_W-1:0]                              SRAM_write_data,
    input  logic [NUM_REGIONS*ADDR_W-1:0]                  Region_base,
    input  logic [NUM_REGIONS*ADDR_W-1:0]                  Region_limit,
    input  logic [NUM_REGIONS-1:0]                         Region_forbid,
    input  logic [NUM_REGIONS-1:0]                         Region_ordered,
    input  logic [((NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1)-1:0] Read_sel,
    output logic [CNT_W-1:0]                               Read_count,
    output logic [CNT_W-1:0]                               Read_order_err,
    output logic [SIG_W-1:0]                               Read_sig,
    output logic                                           Read_complete,
    output logic [CNT_W-1:0]                               Unmapped_count,
    output logic                                           Violation,
    output logic [ADDR_W-1:0]                              Violation_address,
    output logic [DATA_W-1:0]                              Violation_data,
    output logic                                           Armed
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_FROZEN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                   w_sample;
    logic [NUM_REGIONS-1:0] w_inrange;
    logic [NUM_REGIONS-1:0] w_win;
    logic                   w_any_hit;
    logic                   w_forbid_hit;
    logic [SIG_W-1:0]       w_sig_in;

    logic [CNT_W-1:0] w_cnt_all  [NUM_REGIONS];
    logic [CNT_W-1:0] w_err_all  [NUM_REGIONS];
    logic [SIG_W-1:0] w_sig_all  [NUM_REGIONS];
    logic             w_comp_all [NUM_REGIONS];

    // State register
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) r_state <= ST_IDLE;
        else         r_state <= w_state_next;
    end

    // Next state: Start always (re)arms and takes priority over Stop
    always_comb begin
        w_state_next = r_state;
        if (Start)                              w_state_next = ST_ARMED;
        else if (Stop && r_state == ST_ARMED)   w_state_next = ST_FROZEN;
    end

    assign Armed = (r_state == ST_ARMED);

    // A write in the Start cycle belongs to no run, so it is dropped
    assign w_sample = (r_state == ST_ARMED) && !SRAM_we_n && !Start;

    // Signature input: low SIG_W bits of {address, data}, zero-extended if short
    assign w_sig_in = SIG_W'({SRAM_address, SRAM_write_data});

    // Lowest-index matching region wins
    always_comb begin
        logic seen;
        seen  = 1'b0;
        w_win = '0;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            w_win[r] = w_inrange[r] && !seen;
            seen     = seen || w_inrange[r];
        end
        w_any_hit = seen;
    end

    assign w_forbid_hit = w_sample && |(w_win & Region_forbid);

    generate
        for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_region
            logic [ADDR_W-1:0] w_base;
            logic [ADDR_W-1:0] w_limit;
            logic              w_wr;
            logic              w_order_bad;
            logic [CNT_W-1:0]  r_count;
            logic [CNT_W-1:0]  r_err;
            logic [SIG_W-1:0]  r_sig;
            logic              r_complete;
            logic [ADDR_W-1:0] r_expected;

            assign w_base       = Region_base[r*ADDR_W +: ADDR_W];
            assign w_limit      = Region_limit[r*ADDR_W +: ADDR_W];
            // base > limit can never satisfy both comparisons, so it disables the window
            assign w_inrange[r] = (w_base <= SRAM_address) && (SRAM_address <= w_limit);
            assign w_wr         = w_sample && w_win[r];
            assign w_order_bad  = (SRAM_address != r_expected);

            // Per-region statistics; expected address resyncs on every ordered write
            always_ff @(posedge Clock_50 or negedge Resetn) begin
                if (!Resetn) begin
                    r_count    <= '0;
                    r_err      <= '0;
                    r_sig      <= '0;
                    r_complete <= 1'b0;
                    r_expected <= '0;
                end else if (Start) begin
                    r_count    <= '0;
                    r_err      <= '0;
                    r_sig      <= '0;
                    r_complete <= 1'b0;
                    r_expected <= w_base;
                end else if (w_wr) begin
                    if (r_count != c_cnt_max) r_count <= r_count + CNT_W'(1);
                    r_sig <= {r_sig[SIG_W-2:0], r_sig[SIG_W-1]} ^ w_sig_in;
                    if (Region_ordered[r]) begin
                        r_expected <= SRAM_address + ADDR_W'(1);
                        if (w_order_bad && r_err != c_cnt_max) r_err <= r_err + CNT_W'(1);
                        if (SRAM_address == w_limit && r_err == '0 && !w_order_bad)
                            r_complete <= 1'b1;
                    end
                end
            end

            assign w_cnt_all[r]  = r_count;
            assign w_err_all[r]  = r_err;
            assign w_sig_all[r]  = r_sig;
            assign w_comp_all[r] = r_complete;
        end
    endgenerate

    // Writes matching no window
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn)                                   Unmapped_count <= '0;
        else if (Start)                                Unmapped_count <= '0;
        else if (w_sample && !w_any_hit && Unmapped_count != c_cnt_max)
            Unmapped_count <= Unmapped_count + CNT_W'(1);
    end

    // Sticky violation; only the first offending write is captured
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            Violation         <= 1'b0;
            Violation_address <= '0;
            Violation_data    <= '0;
        end else if (Start) begin
            Violation         <= 1'b0;
            Violation_address <= '0;
            Violation_data    <= '0;
        end else if (w_forbid_hit) begin
            Violation <= 1'b1;
            if (!Violation) begin
                Violation_address <= SRAM_address;
                Violation_data    <= SRAM_write_data;
            end
        end
    end

    // Registered readout of the selected region
    always_ff @(posedge Clock_50 or negedge Resetn) begin
        if (!Resetn) begin
            Read_count     <= '0;
            Read_order_err <= '0;
            Read_sig       <= '0;
            Read_complete  <= 1'b0;
        end else begin
            Read_count     <= w_cnt_all[Read_sel];
            Read_order_err <= w_err_all[Read_sel];
            Read_sig       <= w_sig_all[Read_sel];
            Read_complete  <= w_comp_all[Read_sel];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_write_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_write_monitor
// Brief    : Self-checking bench for sram_write_monitor. Directed scenarios
//            plus randomized runs compared against a write-log reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_write_monitor;

    localparam int AW = 18;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int CW = 20;
    localparam int SW = 32;

    logic            Clock_50 = 1'b0;
    logic            Resetn;
    logic            Start, Stop, SRAM_we_n;
    logic [AW-1:0]   SRAM_address;
    logic [DW-1:0]   SRAM_write_data;
    logic [NR*AW-1:0] Region_base, Region_limit;
    logic [NR-1:0]   Region_forbid, Region_ordered;
    logic [1:0]      Read_sel;
    logic [CW-1:0]   Read_count, Read_order_err, Unmapped_count;
    logic [SW-1:0]   Read_sig;
    logic            Read_complete, Violation, Armed;
    logic [AW-1:0]   Violation_address;
    logic [DW-1:0]   Violation_data;

    int n_cmp = 0;
    int n_bad = 0;

    sram_write_monitor #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_REGIONS(NR), .CNT_W(CW), .SIG_W(SW)
    ) dut (
        .Clock_50          (Clock_50),
        .Resetn            (Resetn),
        .Start             (Start),
        .Stop              (Stop),
        .SRAM_we_n         (SRAM_we_n),
        .SRAM_address      (SRAM_address),
        .SRAM_write_data   (SRAM_write_data),
        .Region_base       (Region_base),
        .Region_limit      (Region_limit),
        .Region_forbid     (Region_forbid),
        .Region_ordered    (Region_ordered),
        .Read_sel          (Read_sel),
        .Read_count        (Read_count),
        .Read_order_err    (Read_order_err),
        .Read_sig          (Read_sig),
        .Read_complete     (Read_complete),
        .Unmapped_count    (Unmapped_count),
        .Violation         (Violation),
        .Violation_address (Violation_address),
        .Violation_data    (Violation_data),
        .Armed             (Armed)
    );

    always #10 Clock_50 = ~Clock_50;

    // ---------------- reference model: log of accepted writes per region ----
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    wr_t           m_q [NR][$];
    logic [AW-1:0] m_base0 [NR];
    int            m_state;      // 0 idle, 1 armed, 2 frozen
    int            m_unmapped;
    bit            m_viol;
    logic [AW-1:0] m_vaddr;
    logic [DW-1:0] m_vdata;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] rbase(input int r);
        return Region_base[r*AW +: AW];
    endfunction

    function automatic logic [AW-1:0] rlimit(input int r);
        return Region_limit[r*AW +: AW];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < NR; r++) begin
            m_q[r].delete();
            m_base0[r] = '0;
        end
        m_state = 0; m_unmapped = 0; m_viol = 0; m_vaddr = '0; m_vdata = '0;
    endtask

    task automatic model_step(input bit st, input bit sp, input bit wr,
                              input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (st) begin
            model_reset();
            for (int r = 0; r < NR; r++) m_base0[r] = rbase(r);
            m_state = 1;
        end else begin
            if (wr && m_state == 1) begin
                int hit;
                hit = -1;
                for (int r = NR - 1; r >= 0; r--)
                    if (rbase(r) <= a && a <= rlimit(r)) hit = r;
                if (hit < 0) m_unmapped++;
                else begin
                    wr_t w;
                    w.a = a; w.d = d;
                    m_q[hit].push_back(w);
                    if (Region_forbid[hit] && !m_viol) begin
                        m_viol = 1; m_vaddr = a; m_vdata = d;
                    end else if (Region_forbid[hit]) m_viol = 1;
                end
            end
            if (sp && m_state == 1) m_state = 2;
        end
    endtask

    // Derive the region statistics from its whole write log
    task automatic model_stats(input int r, output logic [CW-1:0] cnt, output logic [CW-1:0] err,
                               output logic [SW-1:0] sig, output bit comp);
        logic [AW-1:0] exp_a;
        logic [AW+DW-1:0] ad;
        int errs;
        cnt = CW'(m_q[r].size());
        sig = '0; errs = 0; comp = 0; exp_a = m_base0[r];
        foreach (m_q[r][i]) begin
            ad  = {m_q[r][i].a, m_q[r][i].d};
            sig = {sig[SW-2:0], sig[SW-1]} ^ ad[SW-1:0];
            if (Region_ordered[r]) begin
                if (m_q[r][i].a != exp_a) errs++;
                exp_a = m_q[r][i].a + 1'b1;
                if (m_q[r][i].a == rlimit(r) && errs == 0) comp = 1;
            end
        end
        err = CW'(errs);
    endtask

    // ---------------- stimulus helpers ---------------------------------------
    task automatic cycle(input bit st, input bit sp, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        Start = st; Stop = sp; SRAM_we_n = !wr; SRAM_address = a; SRAM_write_data = d;
        model_step(st, sp, wr, a, d);
        @(posedge Clock_50);
        #1;
        Start = 0; Stop = 0; SRAM_we_n = 1;
    endtask

    task automatic set_region(input int r, input logic [AW-1:0] b, input logic [AW-1:0] l,
                              input bit f, input bit o);
        Region_base[r*AW +: AW]  = b;
        Region_limit[r*AW +: AW] = l;
        Region_forbid[r]         = f;
        Region_ordered[r]        = o;
    endtask

    task automatic disable_all();
        for (int r = 0; r < NR; r++) set_region(r, 18'h3FFFF, 18'h0, 0, 0);
    endtask

    task automatic check_region(input int r);
        logic [CW-1:0] c, e;
        logic [SW-1:0] s;
        bit cp;
        Read_sel = 2'(r);
        cycle(0, 0, 0, '0, '0);
        model_stats(r, c, e, s, cp);
        check($sformatf("r%0d_count", r), 64'(Read_count), 64'(c));
        check($sformatf("r%0d_order_err", r), 64'(Read_order_err), 64'(e));
        check($sformatf("r%0d_sig", r), 64'(Read_sig), 64'(s));
        check($sformatf("r%0d_complete", r), 64'(Read_complete), 64'(cp));
    endtask

    task automatic check_globals(input string tag);
        check({tag, "_unmapped"}, 64'(Unmapped_count), 64'(m_unmapped));
        check({tag, "_violation"}, 64'(Violation), 64'(m_viol));
        check({tag, "_vaddr"}, 64'(Violation_address), 64'(m_vaddr));
        check({tag, "_vdata"}, 64'(Violation_data), 64'(m_vdata));
    endtask

    // ---------------- main sequence ------------------------------------------
    initial begin
        logic [AW-1:0] ptr, a;
        Resetn = 0; Start = 0; Stop = 0; SRAM_we_n = 1;
        SRAM_address = '0; SRAM_write_data = '0; Read_sel = '0;
        Region_base = '0; Region_limit = '0; Region_forbid = '0; Region_ordered = '0;
        disable_all();
        model_reset();
        repeat (3) @(posedge Clock_50);
        #1 Resetn = 1;
        cycle(0, 0, 0, '0, '0);

        // reset state
        check("rst_armed", 64'(Armed), 64'd0);
        check("rst_count", 64'(Read_count), 64'd0);
        check("rst_sig", 64'(Read_sig), 64'd0);
        check_globals("rst");

        // writes in IDLE, in Start cycle, in Stop cycle, in FROZEN
        set_region(0, 18'h100, 18'h10F, 0, 1);
        cycle(0, 0, 1, 18'h100, 16'h0100);
        cycle(1, 0, 1, 18'h101, 16'h0101);
        check("arm_after_start", 64'(Armed), 64'd1);
        check_region(0);
        check("idle_start_cnt", 64'(Read_count), 64'd0);
        cycle(0, 1, 1, 18'h102, 16'h0102);
        check("arm_after_stop", 64'(Armed), 64'd0);
        cycle(0, 0, 1, 18'h103, 16'h0103);
        check_region(0);
        check("stop_cycle_cnt", 64'(Read_count), 64'd1);

        // clean ordered sequence 0x100..0x10F
        cycle(1, 0, 0, '0, '0);
        for (int i = 0; i < 16; i++) cycle(0, 0, 1, 18'(18'h100 + i), 16'(16'h100 + i));
        cycle(0, 1, 0, '0, '0);
        check_region(0);
        check("seq_count", 64'(Read_count), 64'd16);
        check("seq_err", 64'(Read_order_err), 64'd0);
        check("seq_complete", 64'(Read_complete), 64'd1);

        // one repeat, one skip
        cycle(1, 0, 0, '0, '0);
        cycle(0, 0, 1, 18'h100, 16'h100);
        cycle(0, 0, 1, 18'h101, 16'h101);
        cycle(0, 0, 1, 18'h101, 16'h101);
        for (int i = 3; i < 16; i++) cycle(0, 0, 1, 18'(18'h100 + i), 16'(16'h100 + i));
        cycle(0, 1, 0, '0, '0);
        check_region(0);
        check("skip_count", 64'(Read_count), 64'd16);
        check("skip_err", 64'(Read_order_err), 64'd2);
        check("skip_complete", 64'(Read_complete), 64'd0);

        // forbidden region with first-violation capture
        disable_all();
        set_region(1, 18'h00000, 18'h23DFF, 1, 0);
        cycle(1, 0, 0, '0, '0);
        cycle(0, 0, 1, 18'h00010, 16'hBEEF);
        cycle(0, 0, 1, 18'h00020, 16'h1234);
        cycle(0, 1, 0, '0, '0);
        check("forbid_viol", 64'(Violation), 64'd1);
        check("forbid_vaddr", 64'(Violation_address), 64'h10);
        check("forbid_vdata", 64'(Violation_data), 64'hBEEF);
        check_region(1);

        // overlapping windows and an unmapped write
        disable_all();
        set_region(0, 18'h0, 18'hFF, 0, 0);
        set_region(1, 18'h80, 18'h1FF, 0, 0);
        cycle(1, 0, 0, '0, '0);
        cycle(0, 0, 1, 18'h90, 16'h5A5A);
        cycle(0, 0, 1, 18'h300, 16'hA5A5);
        cycle(0, 1, 0, '0, '0);
        check_region(0);
        check("ovl_r0_count", 64'(Read_count), 64'd1);
        check_region(1);
        check("ovl_r1_count", 64'(Read_count), 64'd0);
        check("ovl_unmapped", 64'(Unmapped_count), 64'd1);

        // asynchronous reset mid-run
        disable_all();
        set_region(0, 18'h0, 18'h3FF, 1, 0);
        cycle(1, 0, 0, '0, '0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1, 18'($urandom_range(0, 18'h3FF)), 16'($urandom));
        check_region(0);
        check("pre_rst_count", 64'(Read_count), 64'd5);
        #4 Resetn = 0;
        #1;
        model_reset();
        check("arst_armed", 64'(Armed), 64'd0);
        check("arst_count", 64'(Read_count), 64'd0);
        check("arst_sig", 64'(Read_sig), 64'd0);
        check_globals("arst");
        @(posedge Clock_50);
        #1 Resetn = 1;
        cycle(1, 1, 0, '0, '0);
        check("start_stop_armed", 64'(Armed), 64'd1);
        cycle(0, 1, 0, '0, '0);

        // randomized runs
        for (int round = 0; round < 8; round++) begin
            for (int r = 0; r < NR; r++) begin
                logic [AW-1:0] b, l;
                b = 18'($urandom_range(0, 18'h300));
                l = 18'(b + $urandom_range(0, 18'h100));
                if ($urandom_range(0, 7) == 0) set_region(r, l + 1'b1, b, 0, 0);
                else set_region(r, b, l, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1);
            end
            ptr = rbase($urandom_range(0, NR - 1));
            cycle(1, 0, 0, '0, '0);
            for (int i = 0; i < 120; i++) begin
                if ($urandom_range(0, 2) != 0) begin
                    a = ptr;
                    case ($urandom_range(0, 15))
                        0:       ptr = ptr;
                        1:       ptr = ptr + 2'd2;
                        default: ptr = ptr + 1'b1;
                    endcase
                end else a = 18'($urandom_range(0, 18'h4FF));
                cycle(0, (i == 119), ($urandom_range(0, 4) != 0), a, 16'($urandom));
            end
            cycle(0, 0, 1, ptr, 16'($urandom));
            for (int r = 0; r < NR; r++) check_region(r);
            check_globals($sformatf("rnd%0d", round));
            check($sformatf("rnd%0d_armed", round), 64'(Armed), 64'd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
